// File: rtl/fp_exponent_aligner.sv
// Operand swap and serial significand alignment for the single-precision adder.
// Define FP_ALIGN_NIBBLE_SHIFT_EN to shift by four positions per cycle when possible.
module fp_exponent_aligner #(
  parameter int SHIFT_CLAMP = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] big_man,
  output logic [26:0] small_man,
  output logic        sign_big,
  output logic        sign_small,
  output logic        swapped,
  output logic        special
);

  localparam int CW = $clog2(SHIFT_CLAMP + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    exp_q, exp_d;
  logic [23:0]   big_q, big_d;
  logic [26:0]   small_q, small_d;
  logic          sb_q, sb_d;
  logic          ss_q, ss_d;
  logic          sw_q, sw_d;
  logic          sp_q, sp_d;

  logic          swap;
  logic [31:0]   hi, lo;
  logic [7:0]    e_hi, e_lo, diff;
  logic [CW-1:0] d;

  always_comb begin
    swap = b[30:0] > a[30:0];
    hi   = swap ? b : a;
    lo   = swap ? a : b;
    e_hi = (hi[30:23] == 8'd0) ? 8'd1 : hi[30:23];
    e_lo = (lo[30:23] == 8'd0) ? 8'd1 : lo[30:23];
    // larger magnitude implies e_hi >= e_lo, so no underflow
    diff = e_hi - e_lo;
    d    = (diff > 8'(SHIFT_CLAMP)) ? CW'(SHIFT_CLAMP) : CW'(diff);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    sb_d    = sb_q;
    ss_d    = ss_q;
    sw_d    = sw_q;
    sp_d    = sp_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = e_hi;
          big_d   = {hi[30:23] != 8'd0, hi[22:0]};
          small_d = {lo[30:23] != 8'd0, lo[22:0], 3'b000};
          cnt_d   = d;
          sb_d    = hi[31];
          ss_d    = lo[31];
          sw_d    = swap;
          sp_d    = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
          state_d = (d == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef FP_ALIGN_NIBBLE_SHIFT_EN
        if (cnt_q >= CW'(4)) begin
          small_d    = {4'b0000, small_q[26:4]};
          small_d[0] = |small_q[4:0];
          cnt_d      = cnt_q - CW'(4);
        end else begin
          small_d    = {1'b0, small_q[26:1]};
          small_d[0] = small_q[1] | small_q[0];
          cnt_d      = cnt_q - CW'(1);
        end
`else
        small_d    = {1'b0, small_q[26:1]};
        small_d[0] = small_q[1] | small_q[0];
        cnt_d      = cnt_q - CW'(1);
`endif
        if (cnt_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      big_q   <= '0;
      small_q <= '0;
      sb_q    <= 1'b0;
      ss_q    <= 1'b0;
      sw_q    <= 1'b0;
      sp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      small_q <= small_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      sw_q    <= sw_d;
      sp_q    <= sp_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign exp_out    = exp_q;
  assign big_man    = big_q;
  assign small_man  = small_q;
  assign sign_big   = sb_q;
  assign sign_small = ss_q;
  assign swapped    = sw_q;
  assign special    = sp_q;

endmodule

// File: tb/tb_fp_exponent_aligner.sv
// Randomized and directed bench for fp_exponent_aligner.
// Expected results come from an arithmetic model of the alignment rules.
module tb_fp_exponent_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_out;
  logic [23:0] big_man;
  logic [26:0] small_man;
  logic        sign_big, sign_small, swapped, special;

  fp_exponent_aligner dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .big_man(big_man), .small_man(small_man),
    .sign_big(sign_big), .sign_small(sign_small),
    .swapped(swapped), .special(special)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  e;
    logic [23:0] bm;
    logic [26:0] sm;
    logic        sb, ss, sw, sp;
    logic [31:0] lat;
  } res_t;

  int   checks = 0;
  int   passes = 0;
  res_t expv;
  bit   mon_en = 0;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t r;
    logic [31:0] hi, lo;
    int eh, el, dd;
    longint unsigned v, lost;
    r.sw = (y[30:0] > x[30:0]);
    hi = r.sw ? y : x;
    lo = r.sw ? x : y;
    eh = (hi[30:23] == 0) ? 1 : int'(hi[30:23]);
    el = (lo[30:23] == 0) ? 1 : int'(lo[30:23]);
    dd = eh - el;
    if (dd > 27) dd = 27;
    v = longint'({(lo[30:23] != 0), lo[22:0]}) * 8;
    lost = v % (64'd1 << dd);
    v = v >> dd;
    if (lost != 0) v = v | 1;
    r.e  = 8'(eh);
    r.bm = {(hi[30:23] != 0), hi[22:0]};
    r.sm = 27'(v);
    r.sb = hi[31];
    r.ss = lo[31];
    r.sp = (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
`ifdef FP_ALIGN_NIBBLE_SHIFT_EN
    r.lat = 32'(1 + dd / 4 + dd % 4);
`else
    r.lat = 32'(1 + dd);
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
  endtask

  function automatic logic [63:0] dut_bundle();
    return {exp_out, big_man, small_man, sign_big, sign_small, swapped, special};
  endfunction

  function automatic logic [63:0] exp_bundle(input res_t r);
    return {r.e, r.bm, r.sm, r.sb, r.ss, r.sw, r.sp};
  endfunction

  // every cycle a result is presented it must equal the model
  always @(negedge clk) begin
    if (mon_en && out_valid)
      check("result", dut_bundle(), exp_bundle(expv));
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input int hold);
    int lat;
    bit seen;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    expv = model(x, y);
    a = x; b = y; in_valid = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
    check("latency", 64'(lat), 64'(expv.lat));
    if (!seen) return;
    repeat (hold) begin
      in_valid = 1'($urandom);
      a = $urandom; b = $urandom;
      @(negedge clk);
      check("hold_valid", {62'd0, out_valid, in_ready}, 64'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("after_hs", {exp_bundle(expv)} ^ dut_bundle() | {62'd0, out_valid, ~in_ready}, 64'd0);
  endtask

  res_t m;
  logic [31:0] ra, rb;

  initial begin
    // model pinned by hand-derived values
    m = model(32'h4B800000, 32'h3F800001);
    check("model_d24_sm", 64'(m.sm), 64'h5);
    m = model(32'h7F000000, 32'h3F800000);
    check("model_clamp", {m.e, 5'd0, m.sm}, {8'hFE, 5'd0, 27'h1});
    m = model(32'h00000001, 32'h00800000);
    check("model_denorm", {m.sw, 3'd0, m.bm, 5'd0, m.sm}, {1'b1, 3'd0, 24'h800000, 5'd0, 27'h8});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", dut_bundle() | {62'd0, out_valid, ~in_ready}, 64'd0);

    run_op(32'h3F800000, 32'h3F000000, 1);
    check("tp1_sm", 64'(small_man), 64'h2000000);
    run_op(32'h3F000000, 32'h40000000, 0);
    check("tp2", {swapped, 7'd0, exp_out, 1'b0, small_man}, {1'b1, 7'd0, 8'h80, 1'b0, 27'h1000000});
    run_op(32'h4B800000, 32'h3F800001, 2);
    check("tp3_sm", 64'(small_man), 64'h5);
    run_op(32'h7F000000, 32'h3F800000, 0);
    check("tp4", {exp_out, 5'd0, small_man}, {8'hFE, 5'd0, 27'h1});
    run_op(32'h00000001, 32'h00800000, 5);
    check("tp5", {swapped, 3'd0, big_man, 5'd0, small_man}, {1'b1, 3'd0, 24'h800000, 5'd0, 27'h8});
    run_op(32'hFF800000, 32'h3F800000, 0);
    check("special", 64'(special), 64'd1);
    run_op(32'h40400000, 32'h40400000, 0);
    check("tie", 64'(swapped), 64'd0);

    // reset in the middle of a d=20 shift
    @(negedge clk);
    mon_en = 0;
    a = 32'h49800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset", dut_bundle() | {62'd0, out_valid, ~in_ready}, 64'd0);
    run_op(32'h3F800000, 32'hBF800000, 1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0)
        rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
      if (i % 7 == 0) ra[30:23] = 8'd0;
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
